mem_stage: RTL and testbench

- Memory stage: consumes the execute-stage EX/MEM register (ALU result, load controls, write-back controls, rd).
- Waits for and captures the load response from the data bus, then aligns and sign/zero-extends the loaded data.
- Selects the register write-back value, drives MEM-stage forwarding, and registers the result into the MEM/WB register for write-back.
- Requests a pipeline stall while a load response is outstanding, and flags a bus timeout.

---
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: waits for and captures load responses, aligns/extends load data,
// selects the write-back value, drives MEM forwarding and the MEM/WB register.
module mem_stage #(
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_sign_i,
  input  logic [1:0]  mem_width_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] next_pc_i,
  input  logic        rf_wr_en_i,
  input  logic [1:0]  rf_wr_src_i,
  input  logic [4:0]  rd_i,
  input  logic        stall_i,
  input  logic        squash_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_wait_ao,
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_rd_o,
  output logic [31:0] fwd_rd_data_o,
  output logic        valid_o,
  output logic        rf_wr_en_o,
  output logic [4:0]  rd_o,
  output logic [31:0] rd_data_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HELD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(RESP_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        err_set;
  logic        load_live;
  logic        timeout;
  logic        mem_wait;
  logic [31:0] load_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  assign load_live = valid_i & mem_read_i & ~squash_i;
  assign timeout   = (state_q == S_WAIT) && (cnt_q == TIMEOUT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    err_set  = 1'b0;
    mem_wait = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_wait = load_live & ~mem_rvalid_i;
        if (load_live) begin
          if (mem_rvalid_i) begin
            if (stall_i) begin
              buf_d   = mem_rdata_i;
              state_d = S_HELD;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      S_WAIT: begin
        mem_wait = load_live & ~mem_rvalid_i & (cnt_q < TIMEOUT);
        if (mem_rvalid_i) begin
          if (stall_i) begin
            buf_d   = mem_rdata_i;
            state_d = S_HELD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          buf_d   = '0;
          err_set = 1'b1;
          state_d = S_HELD;
        end else if (squash_i) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HELD: begin
        if (!stall_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        // The response of the squashed load is still in flight; swallow it.
        mem_wait = load_live;
        if (mem_rvalid_i) begin
          if (load_live) begin
            state_d = S_WAIT;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_raw = mem_rdata_i;
    if (state_q == S_HELD) load_raw = buf_q;
    else if (timeout && !mem_rvalid_i) load_raw = '0;
  end

  always_comb begin
    case (alu_out_i[1:0])
      2'd0:    ld_byte = load_raw[7:0];
      2'd1:    ld_byte = load_raw[15:8];
      2'd2:    ld_byte = load_raw[23:16];
      default: ld_byte = load_raw[31:24];
    endcase
    ld_half = alu_out_i[1] ? load_raw[31:16] : load_raw[15:0];
    case (mem_width_i)
      2'b00:   load_data = {{24{mem_sign_i & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{mem_sign_i & ld_half[15]}}, ld_half};
      default: load_data = load_raw;
    endcase
  end

  always_comb begin
    case (rf_wr_src_i)
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = next_pc_i;
      default: wb_data = alu_out_i;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted.
  assign mem_wait_ao   = ~rst_i & mem_wait;
  assign fwd_valid_o   = ~rst_i & valid_i & rf_wr_en_i & ~squash_i & ~mem_wait & (rd_i != 5'd0);
  assign fwd_rd_o      = rst_i ? 5'd0 : rd_i;
  assign fwd_rd_data_o = rst_i ? 32'd0 : wb_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      if (err_set) bus_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      rf_wr_en_o <= 1'b0;
      rd_o       <= '0;
      rd_data_o  <= '0;
    end else if (stall_i || mem_wait) begin
      valid_o <= 1'b0;
    end else begin
      valid_o    <= valid_i & ~squash_i;
      rf_wr_en_o <= rf_wr_en_i & (rd_i != 5'd0);
      rd_o       <= rd_i;
      rd_data_o  <= wb_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load latency cases, stall hold, timeout, drain and reset.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, mem_read_i, mem_sign_i;
  logic [1:0]  mem_width_i;
  logic [31:0] alu_out_i, next_pc_i;
  logic        rf_wr_en_i;
  logic [1:0]  rf_wr_src_i;
  logic [4:0]  rd_i;
  logic        stall_i, squash_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_wait_ao, fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_rd_data_o;
  logic        valid_o, rf_wr_en_o;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ST_IDLE  = 32'd0;
  localparam logic [31:0] ST_WAIT  = 32'd1;
  localparam logic [31:0] ST_HELD  = 32'd2;
  localparam logic [31:0] ST_DRAIN = 32'd3;

  mem_stage #(.RESP_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_sign_i(mem_sign_i), .mem_width_i(mem_width_i), .alu_out_i(alu_out_i),
    .next_pc_i(next_pc_i), .rf_wr_en_i(rf_wr_en_i), .rf_wr_src_i(rf_wr_src_i),
    .rd_i(rd_i), .stall_i(stall_i), .squash_i(squash_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_wait_ao(mem_wait_ao), .fwd_valid_o(fwd_valid_o),
    .fwd_rd_o(fwd_rd_o), .fwd_rd_data_o(fwd_rd_data_o), .valid_o(valid_o),
    .rf_wr_en_o(rf_wr_en_o), .rd_o(rd_o), .rd_data_o(rd_data_o), .bus_err_o(bus_err_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {30'd0, dut.state_q};
  endfunction

  // driver tasks
  task automatic clr();
    valid_i = 0; mem_read_i = 0; mem_sign_i = 0; mem_width_i = 2'b00;
    alu_out_i = 0; next_pc_i = 0; rf_wr_en_i = 0; rf_wr_src_i = 2'b00; rd_i = 0;
    stall_i = 0; squash_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic set_load(input logic [1:0] w, input logic s, input logic [31:0] a, input logic [4:0] rd);
    valid_i = 1; mem_read_i = 1; mem_width_i = w; mem_sign_i = s; alu_out_i = a;
    next_pc_i = a + 32'h100; rf_wr_en_i = 1; rf_wr_src_i = 2'b01; rd_i = rd;
  endtask

  task automatic set_alu(input logic [31:0] a, input logic [1:0] src, input logic [31:0] pc, input logic [4:0] rd);
    valid_i = 1; mem_read_i = 0; mem_width_i = 2'b10; mem_sign_i = 0; alu_out_i = a;
    next_pc_i = pc; rf_wr_en_i = 1; rf_wr_src_i = src; rd_i = rd;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0]  tw [4];
  logic        ts [4];
  logic [31:0] ta [4];
  logic [31:0] te [4];

  initial begin
    clr();
    rst_i = 1'b1;
    #2;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_rf_wr_en_o", {31'd0, rf_wr_en_o}, 32'd0);
    chk("rst_rd_o", {27'd0, rd_o}, 32'd0);
    chk("rst_rd_data_o", rd_data_o, 32'd0);
    chk("rst_bus_err_o", {31'd0, bus_err_o}, 32'd0);
    chk("rst_mem_wait_ao", {31'd0, mem_wait_ao}, 32'd0);
    chk("rst_fwd_valid_o", {31'd0, fwd_valid_o}, 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // LB signed, response in the same cycle
    set_load(2'b00, 1'b1, 32'h0000_1003, 5'd3);
    mem_rvalid_i = 1; mem_rdata_i = 32'h80AB_CD12;
    settle();
    chk("lb_wait", {31'd0, mem_wait_ao}, 32'd0);
    chk("lb_fwd_valid", {31'd0, fwd_valid_o}, 32'd1);
    chk("lb_fwd_data", fwd_rd_data_o, 32'hFFFF_FF80);
    tick();
    chk("lb_valid_o", {31'd0, valid_o}, 32'd1);
    chk("lb_rd_data", rd_data_o, 32'hFFFF_FF80);
    chk("lb_rd_o", {27'd0, rd_o}, 32'd3);
    chk("lb_state", st(), ST_IDLE);

    // other widths/lanes with zero-latency responses
    tw[0] = 2'b00; ts[0] = 0; ta[0] = 32'h1001; te[0] = 32'h0000_00CD;
    tw[1] = 2'b01; ts[1] = 1; ta[1] = 32'h1000; te[1] = 32'hFFFF_CD12;
    tw[2] = 2'b01; ts[2] = 1; ta[2] = 32'h1003; te[2] = 32'hFFFF_80AB;
    tw[3] = 2'b11; ts[3] = 0; ta[3] = 32'h1001; te[3] = 32'h80AB_CD12;
    for (int i = 0; i < 4; i++) begin
      clr();
      set_load(tw[i], ts[i], ta[i], 5'd12);
      mem_rvalid_i = 1; mem_rdata_i = 32'h80AB_CD12;
      settle();
      chk($sformatf("align%0d_fwd", i), fwd_rd_data_o, te[i]);
      tick();
      chk($sformatf("align%0d_rd_data", i), rd_data_o, te[i]);
    end

    // PC source and rd=0 suppression
    clr();
    set_alu(32'h1234, 2'b10, 32'h0000_0104, 5'd0);
    settle();
    chk("rd0_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
    chk("pc_fwd_data", fwd_rd_data_o, 32'h0000_0104);
    tick();
    chk("rd0_rf_wr_en_o", {31'd0, rf_wr_en_o}, 32'd0);
    chk("pc_rd_data", rd_data_o, 32'h0000_0104);

    // LHU, response three cycles late
    clr();
    set_load(2'b01, 1'b0, 32'h0000_1002, 5'd4);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("lhu_wait%0d", i), {31'd0, mem_wait_ao}, 32'd1);
      chk($sformatf("lhu_fwd_valid%0d", i), {31'd0, fwd_valid_o}, 32'd0);
      tick();
      chk($sformatf("lhu_valid_o%0d", i), {31'd0, valid_o}, 32'd0);
    end
    chk("lhu_state_wait", st(), ST_WAIT);
    mem_rvalid_i = 1; mem_rdata_i = 32'h8765_4321;
    settle();
    chk("lhu_wait_done", {31'd0, mem_wait_ao}, 32'd0);
    chk("lhu_fwd_data", fwd_rd_data_o, 32'h0000_8765);
    tick();
    chk("lhu_valid_o", {31'd0, valid_o}, 32'd1);
    chk("lhu_rd_data", rd_data_o, 32'h0000_8765);
    chk("lhu_state_idle", st(), ST_IDLE);

    // LW whose response arrives during a two-cycle stall
    clr();
    set_load(2'b10, 1'b0, 32'h0000_2000, 5'd6);
    stall_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    chk("held_wait0", {31'd0, mem_wait_ao}, 32'd0);
    tick();
    chk("held_valid0", {31'd0, valid_o}, 32'd0);
    chk("held_state0", st(), ST_HELD);
    mem_rvalid_i = 0; mem_rdata_i = 32'h0BAD_0BAD;
    settle();
    chk("held_wait1", {31'd0, mem_wait_ao}, 32'd0);
    chk("held_fwd_data", fwd_rd_data_o, 32'hDEAD_BEEF);
    tick();
    chk("held_valid1", {31'd0, valid_o}, 32'd0);
    chk("held_state1", st(), ST_HELD);
    stall_i = 0;
    settle();
    tick();
    chk("held_valid_o", {31'd0, valid_o}, 32'd1);
    chk("held_rd_data", rd_data_o, 32'hDEAD_BEEF);
    chk("held_state_idle", st(), ST_IDLE);

    // LW that never gets a response
    clr();
    set_load(2'b10, 1'b0, 32'h0000_2000, 5'd7);
    for (int i = 0; i < 16; i++) begin
      settle();
      chk($sformatf("to_wait%0d", i), {31'd0, mem_wait_ao}, 32'd1);
      tick();
      chk($sformatf("to_valid%0d", i), {31'd0, valid_o}, 32'd0);
    end
    chk("to_err_before", {31'd0, bus_err_o}, 32'd0);
    settle();
    chk("to_wait_end", {31'd0, mem_wait_ao}, 32'd0);
    chk("to_fwd_data", fwd_rd_data_o, 32'd0);
    tick();
    chk("to_bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("to_valid_o", {31'd0, valid_o}, 32'd1);
    chk("to_rd_data", rd_data_o, 32'd0);
    chk("to_rd_o", {27'd0, rd_o}, 32'd7);
    chk("to_state", st(), ST_HELD);
    clr();
    set_alu(32'h0000_0055, 2'b00, 32'h0, 5'd8);
    settle();
    chk("to_next_fwd", fwd_rd_data_o, 32'h0000_0055);
    tick();
    chk("to_next_valid", {31'd0, valid_o}, 32'd1);
    chk("to_next_data", rd_data_o, 32'h0000_0055);
    chk("to_err_sticky", {31'd0, bus_err_o}, 32'd1);
    chk("to_next_state", st(), ST_IDLE);

    // squash while waiting, then a stale response followed by the real one
    clr();
    set_load(2'b10, 1'b0, 32'h0000_3000, 5'd9);
    settle();
    tick();
    squash_i = 1;
    settle();
    chk("sq_wait", {31'd0, mem_wait_ao}, 32'd0);
    tick();
    chk("sq_valid", {31'd0, valid_o}, 32'd0);
    chk("sq_state", st(), ST_DRAIN);
    clr();
    set_load(2'b10, 1'b0, 32'h0000_3004, 5'd10);
    mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
    settle();
    chk("stale_wait", {31'd0, mem_wait_ao}, 32'd1);
    tick();
    chk("stale_valid", {31'd0, valid_o}, 32'd0);
    chk("stale_state", st(), ST_WAIT);
    mem_rdata_i = 32'h2222_2222;
    settle();
    chk("second_wait", {31'd0, mem_wait_ao}, 32'd0);
    chk("second_fwd", fwd_rd_data_o, 32'h2222_2222);
    tick();
    chk("second_valid", {31'd0, valid_o}, 32'd1);
    chk("second_data", rd_data_o, 32'h2222_2222);
    chk("second_rd", {27'd0, rd_o}, 32'd10);

    // reset in the middle of a wait
    clr();
    set_load(2'b10, 1'b0, 32'h0000_4000, 5'd11);
    settle();
    tick();
    chk("mid_state_wait", st(), ST_WAIT);
    rst_i = 1'b1;
    settle();
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_rd_data", rd_data_o, 32'd0);
    chk("mid_rst_rd_o", {27'd0, rd_o}, 32'd0);
    chk("mid_rst_bus_err", {31'd0, bus_err_o}, 32'd0);
    chk("mid_rst_wait", {31'd0, mem_wait_ao}, 32'd0);
    chk("mid_rst_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
    chk("mid_rst_state", st(), ST_IDLE);
    tick();
    rst_i = 1'b0;
    clr();
    set_alu(32'd7, 2'b00, 32'h0, 5'd5);
    settle();
    chk("addi_fwd_valid", {31'd0, fwd_valid_o}, 32'd1);
    tick();
    chk("addi_valid", {31'd0, valid_o}, 32'd1);
    chk("addi_data", rd_data_o, 32'd7);
    chk("addi_rd", {27'd0, rd_o}, 32'd5);
    chk("addi_wr_en", {31'd0, rf_wr_en_o}, 32'd1);

    clr();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
